// File: rtl/imem_boot_ctrl_pkg.sv
// imem_boot_ctrl_pkg: shared sizes, NOP word and boot FSM state encoding
package imem_boot_ctrl_pkg;
   localparam int DEPTH  = 16;
   localparam int ADDR_W = 4;
   localparam int DATA_W = 16;
   localparam logic [DATA_W-1:0] NOP_WORD = 16'h0000;
   localparam logic [1:0] ST_LOAD = 2'd0;
   localparam logic [1:0] ST_FILL = 2'd1;
   localparam logic [1:0] ST_RUN  = 2'd2;
endpackage

// File: rtl/imem_boot_ctrl_if.sv
// imem_boot_ctrl_if: program load port plus core fetch/stall signals
//   master: load source and core (drives load_*, reload_req, pc)
//   slave : boot controller (drives load_ready, instruction, cpu_stall,
//           fetch_err, load_done, words_loaded)
interface imem_boot_ctrl_if;
   import imem_boot_ctrl_pkg::*;
   logic              load_valid;
   logic [DATA_W-1:0] load_data;
   logic              load_last;
   logic              load_ready;
   logic              reload_req;
   logic [15:0]       pc;
   logic [DATA_W-1:0] instruction;
   logic              cpu_stall;
   logic              fetch_err;
   logic              load_done;
   logic [ADDR_W:0]   words_loaded;
   modport master (
      output load_valid, load_data, load_last, reload_req, pc,
      input  load_ready, instruction, cpu_stall, fetch_err, load_done, words_loaded
   );
   modport slave (
      input  load_valid, load_data, load_last, reload_req, pc,
      output load_ready, instruction, cpu_stall, fetch_err, load_done, words_loaded
   );
endinterface

// File: rtl/imem_boot_ctrl_ram.sv
// imem_ram: instruction store, one synchronous write port, one asynchronous read port
//   clk            : write clock
//   we/waddr/wdata : write port
//   raddr/rdata    : combinational read port
module imem_ram #(
   parameter int DEPTH  = 16,
   parameter int ADDR_W = 4,
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);
   logic [DATA_W-1:0] mem [DEPTH];
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end
   assign rdata = mem[raddr];
endmodule

// File: rtl/imem_boot_ctrl.sv
// imem_boot_ctrl: stalls the core while a program is streamed in and NOP-padded, then serves fetches
//   clk   : system clock
//   reset : synchronous active-high reset, returns to LOAD with zeroed counters
//   bus   : load port, reload request, pc in; instruction, stall, fetch error, status out
module imem_boot_ctrl
   import imem_boot_ctrl_pkg::*;
(
   input  logic           clk,
   input  logic           reset,
   imem_boot_ctrl_if.slave bus
);
   logic [1:0]        state;
   logic [ADDR_W-1:0] wr_addr;
   logic [ADDR_W:0]   words_loaded_q;
   logic              load_done_q;
   logic              accept;
   logic              last_slot;
   logic              ram_we;
   logic [DATA_W-1:0] ram_wdata;
   logic [DATA_W-1:0] ram_rdata;
   logic              run;
   always_comb begin
      run       = state == ST_RUN;
      accept    = bus.load_valid && state == ST_LOAD;
      last_slot = wr_addr == ADDR_W'(DEPTH - 1);
      // a reset cycle must never write, even with a word offered
      ram_we    = !reset && (accept || state == ST_FILL);
      ram_wdata = state == ST_FILL ? NOP_WORD : bus.load_data;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= ST_LOAD;
         wr_addr        <= '0;
         words_loaded_q <= '0;
         load_done_q    <= 1'b0;
      end else begin
         load_done_q <= 1'b0;
         if (state == ST_LOAD) begin
            if (accept) begin
               wr_addr        <= wr_addr + 1'b1;
               words_loaded_q <= words_loaded_q + 1'b1;
               if (last_slot) begin
                  state       <= ST_RUN;
                  load_done_q <= 1'b1;
               end else if (bus.load_last) begin
                  state <= ST_FILL;
               end
            end
         end else if (state == ST_FILL) begin
            wr_addr <= wr_addr + 1'b1;
            if (last_slot) begin
               state       <= ST_RUN;
               load_done_q <= 1'b1;
            end
         end else if (state == ST_RUN) begin
            if (bus.reload_req) begin
               state          <= ST_LOAD;
               wr_addr        <= '0;
               words_loaded_q <= '0;
            end
         end else begin
            state <= ST_LOAD;
         end
      end
   end
   imem_ram #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .waddr (wr_addr),
      .wdata (ram_wdata),
      .raddr (bus.pc[ADDR_W:1]),
      .rdata (ram_rdata)
   );
   // the read index ignores pc[0] and the high bits; those only raise fetch_err
   assign bus.instruction  = run ? ram_rdata : NOP_WORD;
   assign bus.fetch_err    = run && (bus.pc[0] || |bus.pc[15:ADDR_W+1]);
   assign bus.load_ready   = state == ST_LOAD;
   assign bus.cpu_stall    = !run;
   assign bus.load_done    = load_done_q;
   assign bus.words_loaded = words_loaded_q;
endmodule

// File: doc/imem_boot_ctrl.md
Name: imem_boot_ctrl

Overview:
Boot/reload controller for the 16x16-bit instruction store of the single-cycle 16-bit MIPS core.
- After reset it holds the core stalled and streams program words into an instruction RAM over a valid/ready load port.
- It pads unloaded entries with NOP, then releases the core and serves combinational fetches from pc[4:1].
- It replaces the file-initialised ROM with a runtime-loadable program store.

Parameters:
DEPTH, 16, number of instruction words (power of two)
ADDR_W, 4, word address width, log2(DEPTH)
DATA_W, 16, instruction width
NOP_WORD, 16'h0000, fill word and instruction output while not running

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
load_valid  input  1  load word present
load_data  input  DATA_W  program word to write
load_last  input  1  qualifies final word of the program
load_ready  output  1  controller accepts a word this cycle
reload_req  input  1  one-cycle request to reload the program
pc  input  16  byte program counter from the core
instruction  output  DATA_W  fetched instruction
cpu_stall  output  1  core must hold pc and not commit
fetch_err  output  1  pc misaligned or out of range
load_done  output  1  one-cycle pulse on entering RUN
words_loaded  output  ADDR_W+1  count of words accepted in current load

Behaviour:
- Interface: one clock `clk`; `reset` is synchronous and active-high.
- States: LOAD, FILL, RUN. Reset to LOAD.
- Reset values:
  - wr_addr=0, words_loaded=0, load_done=0.
  - load_ready=1 and cpu_stall=1, since state is LOAD.
  - instruction=NOP_WORD, fetch_err=0.
  - RAM contents are not cleared by reset.
- load_ready = (state==LOAD), combinational. cpu_stall = (state!=RUN).
- LOAD:
  - Each cycle with load_valid&&load_ready: write load_data to RAM[wr_addr], wr_addr+1, words_loaded+1.
  - Accept with wr_addr==DEPTH-1 (regardless of load_last) -> RUN.
  - Accept with load_last and wr_addr<DEPTH-1 -> FILL, wr_addr advanced to the next entry.
  - load_valid low: no change; stays in LOAD indefinitely.
- FILL:
  - Writes NOP_WORD to RAM[wr_addr] each cycle and increments wr_addr.
  - After writing DEPTH-1 -> RUN.
  - load_ready=0; load_valid is ignored.
- RUN:
  - instruction = RAM[pc[ADDR_W:1]], combinational, zero latency.
  - fetch_err = pc[0] | (pc[15:ADDR_W+1]!=0). The read still uses pc[ADDR_W:1].
  - reload_req=1 -> LOAD next cycle with wr_addr=0 and words_loaded=0. Next cycle cpu_stall=1 and instruction=NOP_WORD.
- Outside RUN: instruction=NOP_WORD, fetch_err=0.
- load_done:
  - Registered; high exactly the first cycle the state is RUN.
  - Not re-asserted until the next LOAD->RUN pass.
- reload_req in LOAD or FILL: ignored, no effect on counters.
- words_loaded: counts accepted load words only (not fill writes). Maximum DEPTH (16), so ADDR_W+1 bits never overflow.
- wr_addr wraps naturally. The DEPTH-1 transition rule guarantees no write beyond the array.
- Reset during LOAD/FILL/RUN: next cycle is LOAD with zeroed counters. Partial RAM contents remain but are not visible, because instruction=NOP while stalled.
- Simultaneous reset and load_valid: reset wins, no write.
- Write and read in the same cycle cannot collide: fetch reads only in RUN, and writes occur only in LOAD/FILL.

Decomposition:
- Shared package: state encoding (LOAD=2'd0, FILL=2'd1, RUN=2'd2) and the NOP_WORD constant, shared with the core's decode/NOP handling.
- One sub-module, imem_ram: DEPTH x DATA_W, single synchronous write port (we, waddr, wdata), single asynchronous read port. No initialisation file.
- The controller FSM, counters and fetch-error logic live in imem_boot_ctrl.

Test Plan:
1. Full load: reset, then 16 back-to-back words 16'h1000+i with load_last on word 15.
   - RUN after the 16th accept; load_done pulses once; words_loaded=16.
   - pc=16'h0006 -> instruction=16'h1003, cpu_stall=0.
2. Short load with fill: 7 words (the 7-instruction lw/lw/beq/sub/sw/add/sw program), load_last on word 6.
   - FILL writes entries 7..15; RUN reached 9 cycles after the last accept.
   - pc=16'h0010 -> NOP_WORD; words_loaded=7.
3. Backpressure/gaps: load_valid toggled 1,0,0,1.
   - Only asserted cycles write; wr_addr holds during gaps.
   - load_ready=0 throughout FILL even with load_valid=1, and no extra writes occur.
4. Fetch error in RUN:
   - pc=16'h0003 -> fetch_err=1, instruction=RAM[1].
   - pc=16'h0020 -> fetch_err=1.
   - pc=16'h001E -> fetch_err=0, instruction=RAM[15].
5. Reload: reload_req in RUN.
   - Next cycle LOAD, cpu_stall=1, instruction=NOP, words_loaded=0.
   - Load 2 new words with load_last -> RAM[0..1] new, RAM[2..15]=NOP.
6. Reset mid-load after 5 words: next cycle LOAD, wr_addr=0, words_loaded=0. reload_req pulsed during LOAD has no effect.
